// File: rtl/mcast_group_table_pkg.sv
// mcast_group_table_pkg
// Shared types and constants for the multicast group table.
//   ADDR_WIDTH     - width of fabric addresses classified by the table
//   GROUP_ID_BITS  - width of a group id on the lookup and config paths
//   HIT_CNT_WIDTH  - width of the optional per-entry hit counters
//   cfg_op_e       - runtime config command encoding
package mcast_group_table_pkg;

    localparam int ADDR_WIDTH    = 32;
    localparam int GROUP_ID_BITS = 4;
    localparam int HIT_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        CFG_WRITE      = 2'd0,
        CFG_INVALIDATE = 2'd1,
        CFG_READ       = 2'd2,
        CFG_RSVD       = 2'd3
    } cfg_op_e;

endpackage

// File: rtl/mcast_group_table_if.sv
// mcast_group_table_if
// Bundles the lookup, result and config channels of the multicast group table.
//   lookup_*  : request from command decode (valid/ready)
//   result_*, member_mask, group_id, is_multicast_addr : registered result (valid/ready)
//   cfg_*     : single-cycle config strobe and WRITE payload
//   cfg_rd_*  : read-back data, cfg_rd_valid pulses one cycle
// modport master drives requests/config; modport slave is the table.
interface mcast_group_table_if #(
    parameter int NUM_PORTS = 4
);
    import mcast_group_table_pkg::*;

    logic                     lookup_valid;
    logic                     lookup_ready;
    logic [ADDR_WIDTH-1:0]    lookup_addr;

    logic                     result_valid;
    logic                     result_ready;
    logic [NUM_PORTS-1:0]     member_mask;
    logic [GROUP_ID_BITS-1:0] group_id;
    logic                     is_multicast_addr;

    logic                     cfg_valid;
    cfg_op_e                  cfg_op;
    logic [GROUP_ID_BITS-1:0] cfg_group_id;
    logic [ADDR_WIDTH-1:0]    cfg_base_addr;
    logic [ADDR_WIDTH-1:0]    cfg_addr_mask;
    logic [NUM_PORTS-1:0]     cfg_member_mask;

    logic                     cfg_rd_valid;
    logic [ADDR_WIDTH-1:0]    cfg_rd_base;
    logic [ADDR_WIDTH-1:0]    cfg_rd_mask;
    logic [NUM_PORTS-1:0]     cfg_rd_members;
    logic                     cfg_rd_entry_valid;
    logic [HIT_CNT_WIDTH-1:0] cfg_rd_hits;

    modport master (
        output lookup_valid, lookup_addr, result_ready,
        output cfg_valid, cfg_op, cfg_group_id, cfg_base_addr, cfg_addr_mask, cfg_member_mask,
        input  lookup_ready, result_valid, member_mask, group_id, is_multicast_addr,
        input  cfg_rd_valid, cfg_rd_base, cfg_rd_mask, cfg_rd_members, cfg_rd_entry_valid, cfg_rd_hits
    );

    modport slave (
        input  lookup_valid, lookup_addr, result_ready,
        input  cfg_valid, cfg_op, cfg_group_id, cfg_base_addr, cfg_addr_mask, cfg_member_mask,
        output lookup_ready, result_valid, member_mask, group_id, is_multicast_addr,
        output cfg_rd_valid, cfg_rd_base, cfg_rd_mask, cfg_rd_members, cfg_rd_entry_valid, cfg_rd_hits
    );

endinterface

// File: rtl/mcast_group_table_group_match_enc.sv
// group_match_enc
// Combinational priority encoder for the table match vector.
//   match_i     - one bit per entry, set when that entry matches
//   any_match_o - at least one entry matched
//   idx_o       - lowest matching index (0 when nothing matched)
module group_match_enc #(
    parameter int NUM_GROUPS = 8,
    parameter int IDX_W      = $clog2(NUM_GROUPS)
) (
    input  logic [NUM_GROUPS-1:0] match_i,
    output logic                  any_match_o,
    output logic [IDX_W-1:0]      idx_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        any_match_o = |match_i;
        idx_o       = '0;
        for (int i = NUM_GROUPS - 1; i >= 0; i--) begin
            if (match_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mcast_group_table.sv
// mcast_group_table
// Maps a LOAD_REDUCE / STORE_MC address to a participant node mask and group
// id through a one-stage registered lookup, with runtime WRITE / INVALIDATE /
// READ of table entries.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mcast_group_table_if.slave (lookup, result, config, read-back)
// Optional build macro MCAST_HIT_CNT_EN adds a 16-bit saturating hit counter
// per entry; without it cfg_rd_hits reads as zero.
module mcast_group_table
    import mcast_group_table_pkg::*;
#(
    parameter int                    NUM_PORTS    = 4,
    parameter int                    NUM_GROUPS   = 8,
    parameter int                    NODE_SEL_LSB = 12,
    parameter logic [ADDR_WIDTH-1:0] GROUP0_BASE  = 32'h1000_0000,
    parameter logic [ADDR_WIDTH-1:0] GROUP0_MASK  = 32'hF000_0000,
    parameter logic [ADDR_WIDTH-1:0] GROUP1_BASE  = 32'h2000_0000,
    parameter logic [ADDR_WIDTH-1:0] GROUP1_MASK  = 32'hF000_0000,
    parameter logic [ADDR_WIDTH-1:0] GROUP2_BASE  = 32'h3000_0000,
    parameter logic [ADDR_WIDTH-1:0] GROUP2_MASK  = 32'hF000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    mcast_group_table_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_GROUPS);
    localparam int SEL_W = $clog2(NUM_PORTS);
    localparam int HALF  = NUM_PORTS / 2;
    localparam logic [NUM_PORTS-1:0] LOW_HALF  = {{HALF{1'b0}}, {HALF{1'b1}}};
    localparam logic [NUM_PORTS-1:0] HIGH_HALF = ~LOW_HALF;

    // The member vector width follows NUM_PORTS, so the entry type lives here.
    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] base;
        logic [ADDR_WIDTH-1:0] mask;
        logic [NUM_PORTS-1:0]  members;
    } group_entry_t;

    function automatic group_entry_t resetEntry(input int idx);
        group_entry_t e;
        e = '0;
        case (idx)
            0: begin e.valid = 1'b1; e.base = GROUP0_BASE; e.mask = GROUP0_MASK; e.members = '1;        end
            1: begin e.valid = 1'b1; e.base = GROUP1_BASE; e.mask = GROUP1_MASK; e.members = LOW_HALF;  end
            2: begin e.valid = 1'b1; e.base = GROUP2_BASE; e.mask = GROUP2_MASK; e.members = HIGH_HALF; end
            default: ;
        endcase
        return e;
    endfunction

    group_entry_t              entries_q [NUM_GROUPS];
    group_entry_t              entries_d [NUM_GROUPS];
    logic [NUM_GROUPS-1:0]     matchVec;
    logic                      anyMatch;
    logic [IDX_W-1:0]          matchIdx;
    logic [SEL_W-1:0]          nodeSel;
    logic [NUM_PORTS-1:0]      missMask;
    logic                      accept;
    logic                      cfgInRange;
    logic [IDX_W-1:0]          cfgIdx;
    logic                      cfgWrite;
    logic                      cfgInval;
    logic                      cfgRead;
    logic [HIT_CNT_WIDTH-1:0]  rdHitsSel;

    logic                      resValid_q;
    logic [NUM_PORTS-1:0]      resMask_q;
    logic [GROUP_ID_BITS-1:0]  resId_q;
    logic                      resMc_q;

    logic                      rdValid_q;
    logic [ADDR_WIDTH-1:0]     rdBase_q;
    logic [ADDR_WIDTH-1:0]     rdMask_q;
    logic [NUM_PORTS-1:0]      rdMembers_q;
    logic                      rdEntryValid_q;
    logic [HIT_CNT_WIDTH-1:0]  rdHits_q;

    // Ready depends only on the output register and the downstream ready,
    // never on lookup_valid, so there is no valid->ready combinational path.
    assign bus.lookup_ready = !resValid_q || bus.result_ready;
    assign accept           = bus.lookup_valid && bus.lookup_ready;

    assign nodeSel  = bus.lookup_addr[NODE_SEL_LSB +: SEL_W];
    assign missMask = {{(NUM_PORTS-1){1'b0}}, 1'b1} << nodeSel;

    // Out-of-range ids are filtered here so writes/invalidates become no-ops.
    assign cfgInRange = (32'(bus.cfg_group_id) < NUM_GROUPS);
    assign cfgIdx     = bus.cfg_group_id[IDX_W-1:0];
    assign cfgWrite   = bus.cfg_valid && (bus.cfg_op == CFG_WRITE) && cfgInRange;
    assign cfgInval   = bus.cfg_valid && (bus.cfg_op == CFG_INVALIDATE) && cfgInRange;
    assign cfgRead    = bus.cfg_valid && (bus.cfg_op == CFG_READ);

    // Matching looks at the registered table, so a same-cycle config update
    // only affects lookups accepted from the next cycle on.
    always_comb begin
        matchVec = '0;
        for (int i = 0; i < NUM_GROUPS; i++) begin
            matchVec[i] = entries_q[i].valid &&
                          ((bus.lookup_addr & entries_q[i].mask) == entries_q[i].base);
        end
    end

    group_match_enc #(
        .NUM_GROUPS (NUM_GROUPS),
        .IDX_W      (IDX_W)
    ) u_enc (
        .match_i     (matchVec),
        .any_match_o (anyMatch),
        .idx_o       (matchIdx)
    );

    // Next table state: WRITE replaces the whole entry, INVALIDATE only drops
    // the valid bit so a later READ still shows the old fields.
    always_comb begin
        for (int i = 0; i < NUM_GROUPS; i++) begin
            entries_d[i] = entries_q[i];
        end
        if (cfgWrite) begin
            entries_d[cfgIdx].valid   = 1'b1;
            entries_d[cfgIdx].base    = bus.cfg_base_addr;
            entries_d[cfgIdx].mask    = bus.cfg_addr_mask;
            entries_d[cfgIdx].members = bus.cfg_member_mask;
        end
        if (cfgInval) begin
            entries_d[cfgIdx].valid = 1'b0;
        end
    end

    // Table storage, restored to the parameter defaults on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_GROUPS; i++) begin
                entries_q[i] <= resetEntry(i);
            end
        end else begin
            for (int i = 0; i < NUM_GROUPS; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

`ifdef MCAST_HIT_CNT_EN
    logic [HIT_CNT_WIDTH-1:0] hitCnt_q [NUM_GROUPS];
    logic [HIT_CNT_WIDTH-1:0] hitCnt_d [NUM_GROUPS];

    // A WRITE clear is applied after the increment so it wins on a same-cycle hit.
    always_comb begin
        for (int i = 0; i < NUM_GROUPS; i++) begin
            hitCnt_d[i] = hitCnt_q[i];
            if (accept && anyMatch && (matchIdx == IDX_W'(i)) && (hitCnt_q[i] != '1)) begin
                hitCnt_d[i] = hitCnt_q[i] + HIT_CNT_WIDTH'(1);
            end
            if (cfgWrite && (cfgIdx == IDX_W'(i))) begin
                hitCnt_d[i] = '0;
            end
        end
    end

    // Hit counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_GROUPS; i++) begin
                hitCnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_GROUPS; i++) begin
                hitCnt_q[i] <= hitCnt_d[i];
            end
        end
    end

    assign rdHitsSel = cfgInRange ? hitCnt_d[cfgIdx] : '0;
`else
    assign rdHitsSel = '0;
`endif

    // Result register: loads on accept, otherwise drains on a handshake and
    // holds its fields while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resValid_q <= 1'b0;
            resMask_q  <= '0;
            resId_q    <= '0;
            resMc_q    <= 1'b0;
        end else if (accept) begin
            resValid_q <= 1'b1;
            resMask_q  <= anyMatch ? entries_q[matchIdx].members : missMask;
            resId_q    <= anyMatch ? GROUP_ID_BITS'(matchIdx) : '0;
            resMc_q    <= anyMatch;
        end else if (bus.result_ready) begin
            resValid_q <= 1'b0;
        end
    end

    // Read-back capture uses next-state values so a same-cycle WRITE or
    // INVALIDATE is visible in the returned data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdValid_q      <= 1'b0;
            rdBase_q       <= '0;
            rdMask_q       <= '0;
            rdMembers_q    <= '0;
            rdEntryValid_q <= 1'b0;
            rdHits_q       <= '0;
        end else begin
            rdValid_q <= cfgRead;
            if (cfgRead) begin
                rdHits_q <= rdHitsSel;
                if (cfgInRange) begin
                    rdBase_q       <= entries_d[cfgIdx].base;
                    rdMask_q       <= entries_d[cfgIdx].mask;
                    rdMembers_q    <= entries_d[cfgIdx].members;
                    rdEntryValid_q <= entries_d[cfgIdx].valid;
                end else begin
                    rdBase_q       <= '0;
                    rdMask_q       <= '0;
                    rdMembers_q    <= '0;
                    rdEntryValid_q <= 1'b0;
                end
            end
        end
    end

    assign bus.result_valid       = resValid_q;
    assign bus.member_mask        = resMask_q;
    assign bus.group_id           = resId_q;
    assign bus.is_multicast_addr  = resMc_q;
    assign bus.cfg_rd_valid       = rdValid_q;
    assign bus.cfg_rd_base        = rdBase_q;
    assign bus.cfg_rd_mask        = rdMask_q;
    assign bus.cfg_rd_members     = rdMembers_q;
    assign bus.cfg_rd_entry_valid = rdEntryValid_q;
    assign bus.cfg_rd_hits        = rdHits_q;

endmodule

// File: tb/tb_mcast_group_table.sv
// tb_mcast_group_table
// Directed scoreboard bench for mcast_group_table (default parameters).
// Expected results are queued when a lookup or READ is issued; a monitor pops
// and compares whenever the DUT hands a result over. Hit-count expectations
// follow the MCAST_HIT_CNT_EN build macro.
module tb_mcast_group_table;
    import mcast_group_table_pkg::*;

`ifdef MCAST_HIT_CNT_EN
    localparam int HIT_EN = 1;
`else
    localparam int HIT_EN = 0;
`endif

    typedef struct packed {
        logic [3:0]               mask;
        logic [GROUP_ID_BITS-1:0] id;
        logic                     mc;
    } res_t;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] mask;
        logic [3:0]  members;
        logic        ev;
        logic [15:0] hits;
    } rd_t;

    logic clk = 1'b0;
    logic rst_n;
    res_t expQ[$];
    rd_t  rdQ[$];
    int   testsRun    = 0;
    int   testsFailed = 0;

    always #5 clk = ~clk;

    mcast_group_table_if #(.NUM_PORTS(4)) bus();

    mcast_group_table dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Single comparison point: every check in the bench funnels through here.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Hold a lookup until accepted, then queue its expected result.
    task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] mask,
                                 input int id, input logic mc);
        logic acc;
        acc = 1'b0;
        bus.lookup_valid = 1'b1;
        bus.lookup_addr  = addr;
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clk);
            acc = bus.lookup_ready;
            @(posedge clk);
            #1;
        end
        if (acc) begin
            expQ.push_back('{mask: mask, id: GROUP_ID_BITS'(id), mc: mc});
        end else begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL lookup accept timeout: got no accept, expected accept for 0x%08h", addr);
        end
    endtask

    task automatic idleLookup();
        bus.lookup_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic cfgCmd(input cfg_op_e op, input int id, input logic [31:0] base,
                          input logic [31:0] mask, input logic [3:0] members);
        bus.cfg_op          = op;
        bus.cfg_group_id    = GROUP_ID_BITS'(id);
        bus.cfg_base_addr   = base;
        bus.cfg_addr_mask   = mask;
        bus.cfg_member_mask = members;
        bus.cfg_valid       = 1'b1;
        @(posedge clk);
        #1;
        bus.cfg_valid       = 1'b0;
    endtask

    task automatic cfgRead(input int id, input rd_t exp);
        rdQ.push_back(exp);
        cfgCmd(CFG_READ, id, 32'h0, 32'h0, 4'h0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: compares outputs whenever a result handshake or a read-back
    // pulse is presented, sampled on the falling edge.
    always @(negedge clk) begin : monitor
        res_t e;
        rd_t  r;
        if (rst_n === 1'b1 && bus.result_valid && bus.result_ready) begin
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected result: got id %0d mask 0x%0h, expected none",
                         bus.group_id, bus.member_mask);
            end else begin
                e = expQ.pop_front();
                checkOutput("result member_mask", 32'(bus.member_mask), 32'(e.mask));
                checkOutput("result group_id", 32'(bus.group_id), 32'(e.id));
                checkOutput("result is_multicast_addr", 32'(bus.is_multicast_addr), 32'(e.mc));
            end
        end
        if (rst_n === 1'b1 && bus.cfg_rd_valid) begin
            if (rdQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected read-back: got base 0x%0h, expected none", bus.cfg_rd_base);
            end else begin
                r = rdQ.pop_front();
                checkOutput("rd base", bus.cfg_rd_base, r.base);
                checkOutput("rd mask", bus.cfg_rd_mask, r.mask);
                checkOutput("rd members", 32'(bus.cfg_rd_members), 32'(r.members));
                checkOutput("rd entry_valid", 32'(bus.cfg_rd_entry_valid), 32'(r.ev));
                checkOutput("rd hits", 32'(bus.cfg_rd_hits), 32'(r.hits));
            end
        end
    end

    // Watchdog so the run always ends even if the DUT wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n               = 1'b0;
        bus.lookup_valid    = 1'b0;
        bus.lookup_addr     = '0;
        bus.result_ready    = 1'b1;
        bus.cfg_valid       = 1'b0;
        bus.cfg_op          = CFG_WRITE;
        bus.cfg_group_id    = '0;
        bus.cfg_base_addr   = '0;
        bus.cfg_addr_mask   = '0;
        bus.cfg_member_mask = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset result_valid", 32'(bus.result_valid), 0);
        checkOutput("reset member_mask", 32'(bus.member_mask), 0);
        checkOutput("reset group_id", 32'(bus.group_id), 0);
        checkOutput("reset is_multicast", 32'(bus.is_multicast_addr), 0);
        checkOutput("reset cfg_rd_valid", 32'(bus.cfg_rd_valid), 0);
        checkOutput("reset cfg_rd_hits", 32'(bus.cfg_rd_hits), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post-reset lookup_ready", 32'(bus.lookup_ready), 1);

        // Default table, back-to-back lookups
        applyStimulus(32'h1000_0040, 4'b1111, 0, 1'b1);
        applyStimulus(32'h2ABC_0000, 4'b0011, 1, 1'b1);
        applyStimulus(32'h3000_0000, 4'b1100, 2, 1'b1);
        applyStimulus(32'h0000_2000, 4'b0100, 0, 1'b0);
        idleLookup();

        // Priority: lower index wins, then invalidate exposes entry 5
        cfgCmd(CFG_WRITE, 5, 32'h1000_0000, 32'hFFFF_0000, 4'b1010);
        applyStimulus(32'h1000_1234, 4'b1111, 0, 1'b1);
        idleLookup();
        cfgCmd(CFG_INVALIDATE, 0, 32'h0, 32'h0, 4'h0);
        applyStimulus(32'h1000_1234, 4'b1010, 5, 1'b1);
        idleLookup();
        cfgRead(0, '{base: 32'h1000_0000, mask: 32'hF000_0000, members: 4'b1111,
                     ev: 1'b0, hits: 16'(2 * HIT_EN)});

        // Backpressure: stall for 3 cycles with the next lookup pending
        bus.result_ready = 1'b0;
        applyStimulus(32'h2000_0000, 4'b0011, 1, 1'b1);
        bus.lookup_addr = 32'h3000_0000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("stall lookup_ready", 32'(bus.lookup_ready), 0);
            checkOutput("stall result_valid", 32'(bus.result_valid), 1);
            checkOutput("stall held mask", 32'(bus.member_mask), 32'h3);
            checkOutput("stall held id", 32'(bus.group_id), 1);
        end
        @(posedge clk);
        #1;
        bus.result_ready = 1'b1;
        applyStimulus(32'h3000_0000, 4'b1100, 2, 1'b1);
        applyStimulus(32'h0000_1000, 4'b0010, 0, 1'b0);
        applyStimulus(32'h1000_5555, 4'b1010, 5, 1'b1);
        idleLookup();
        checkOutput("backpressure all delivered", 32'(expQ.size()), 0);

        // Same-cycle WRITE and lookup: lookup sees the old table
        bus.cfg_op          = CFG_WRITE;
        bus.cfg_group_id    = GROUP_ID_BITS'(3);
        bus.cfg_base_addr   = 32'h4000_0000;
        bus.cfg_addr_mask   = 32'hF000_0000;
        bus.cfg_member_mask = 4'b0001;
        bus.cfg_valid       = 1'b1;
        applyStimulus(32'h4000_0000, 4'b0001, 0, 1'b0);
        bus.cfg_valid       = 1'b0;
        applyStimulus(32'h4000_0000, 4'b0001, 3, 1'b1);
        idleLookup();

        // Hit counting and read-back
        cfgCmd(CFG_WRITE, 1, 32'h2000_0000, 32'hF000_0000, 4'b0011);
        applyStimulus(32'h2000_0001, 4'b0011, 1, 1'b1);
        applyStimulus(32'h2100_0000, 4'b0011, 1, 1'b1);
        applyStimulus(32'h2FFF_FFFF, 4'b0011, 1, 1'b1);
        idleLookup();
        cfgRead(1, '{base: 32'h2000_0000, mask: 32'hF000_0000, members: 4'b0011,
                     ev: 1'b1, hits: 16'(3 * HIT_EN)});
        cfgCmd(CFG_WRITE, 1, 32'h2000_0000, 32'hF000_0000, 4'b0011);
        cfgRead(1, '{base: 32'h2000_0000, mask: 32'hF000_0000, members: 4'b0011,
                     ev: 1'b1, hits: 16'h0});
        cfgRead(9, '{base: 32'h0, mask: 32'h0, members: 4'b0000, ev: 1'b0, hits: 16'h0});

        // Reset while a result is pending
        bus.result_ready = 1'b0;
        applyStimulus(32'h3000_0000, 4'b1100, 2, 1'b1);
        bus.lookup_valid = 1'b0;
        rst_n = 1'b0;
        expQ.delete();
        #2;
        checkOutput("mid reset result_valid", 32'(bus.result_valid), 0);
        checkOutput("mid reset member_mask", 32'(bus.member_mask), 0);
        checkOutput("mid reset group_id", 32'(bus.group_id), 0);
        checkOutput("mid reset is_multicast", 32'(bus.is_multicast_addr), 0);
        checkOutput("mid reset rd_members", 32'(bus.cfg_rd_members), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.result_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("after reset lookup_ready", 32'(bus.lookup_ready), 1);
        applyStimulus(32'h1000_0040, 4'b1111, 0, 1'b1);
        applyStimulus(32'h4000_0000, 4'b0001, 0, 1'b0);
        applyStimulus(32'h1000_5555, 4'b1111, 0, 1'b1);
        idleLookup();
        cfgRead(5, '{base: 32'h0, mask: 32'h0, members: 4'b0000, ev: 1'b0, hits: 16'h0});
        cfgRead(0, '{base: 32'h1000_0000, mask: 32'hF000_0000, members: 4'b1111,
                     ev: 1'b1, hits: 16'(2 * HIT_EN)});

        repeat (5) @(posedge clk);
        #1;
        checkOutput("result queue drained", 32'(expQ.size()), 0);
        checkOutput("read queue drained", 32'(rdQ.size()), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mcast_group_table.md
# mcast_group_table

Parametrised multicast group table for the switch fabric, successor to the fixed 4-entry table. It maps a LOAD_REDUCE / STORE_MC address to a participant node mask and group id through a registered lookup pipeline with valid/ready backpressure on both sides. It also supports runtime write, invalidate and read-back of entries, plus optional per-group hit counters. It sits between command decode and the reduce/multicast engines.

## Interface
- NUM_PORTS, 4: switch ports / nodes; member-mask width; even, ≥2.
- NUM_GROUPS, 8: table entries; power of two, ≤ 2**GROUP_ID_BITS.
- NODE_SEL_LSB, 12: LSB of the address field that selects the node on a miss.
- GROUP0_BASE/GROUP0_MASK, 32'h1000_0000/32'hF000_0000: reset entry 0, all nodes.
- GROUP1_BASE/GROUP1_MASK, 32'h2000_0000/32'hF000_0000: reset entry 1, lower half of nodes.
- GROUP2_BASE/GROUP2_MASK, 32'h3000_0000/32'hF000_0000: reset entry 2, upper half of nodes.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- lookup_valid / lookup_ready  in / out  1 / 1  lookup request handshake.
- lookup_addr  in  ADDR_WIDTH  address to classify.
- result_valid / result_ready  out / in  1 / 1  result handshake.
- member_mask  out  NUM_PORTS  participating nodes.
- group_id  out  GROUP_ID_BITS  matched entry; 0 on a miss.
- is_multicast_addr  out  1  1 = an entry matched.
- cfg_valid  in  1  config command strobe, single cycle, always accepted.
- cfg_op  in  2  0 = WRITE, 1 = INVALIDATE, 2 = READ, 3 = reserved (no-op).
- cfg_group_id  in  GROUP_ID_BITS  target entry; ids ≥ NUM_GROUPS are ignored (READ returns zeros).
- cfg_base_addr, cfg_addr_mask  in  ADDR_WIDTH  WRITE payload.
- cfg_member_mask  in  NUM_PORTS  WRITE payload.
- cfg_rd_valid  out  1  READ data valid, one cycle.
- cfg_rd_base, cfg_rd_mask  out  ADDR_WIDTH  read-back address fields.
- cfg_rd_members  out  NUM_PORTS  read-back member mask.
- cfg_rd_entry_valid  out  1  read-back entry valid bit.
- cfg_rd_hits  out  16  read-back hit count; 0 when counters are compiled out.

## Operation
- Entry i matches when it is valid and (addr & mask_i) == base_i. The lowest matching index wins.
- Miss: member_mask is the one-hot of lookup_addr[NODE_SEL_LSB +: $clog2(NUM_PORTS)]; group_id = 0; is_multicast_addr = 0.
- Reset table: entries 0–2 from the parameters with members all-ones / low half / high half. Entries 3..NUM_GROUPS-1 are invalid, zeroed.
- Match is evaluated on lookup_addr in the accept cycle against the table state before any same-cycle cfg update. The result is registered.
- WRITE stores all three fields and sets valid. INVALIDATE clears valid only and leaves the fields intact. Both take effect at the clock edge.
- READ captures the entry, including any same-cycle WRITE/INVALIDATE, into the cfg_rd_* registers. cfg_rd_valid pulses the next cycle.

## Timing
- lookup_ready = !result_valid || result_ready. This gives full throughput of one lookup per cycle, with no combinational path from lookup_valid to lookup_ready.
- Accept in cycle N → result_valid in N+1. The result fields stay stable while result_valid && !result_ready.
- result_valid drops after a result_ready handshake unless a new lookup is accepted in the same cycle.
- Reset values: result_valid=0, member_mask=0, group_id=0, is_multicast_addr=0, cfg_rd_*=0, all hit counters 0.
- Async reset mid-lookup drops the pending result. lookup_ready returns to 1 on the first clock after deassertion.

## Configuration
- MCAST_HIT_CNT_EN: each entry has a 16-bit saturating hit counter.
  - The counter increments when that entry is the winning match of an accepted lookup.
  - It saturates at 16'hFFFF.
  - A WRITE to the entry clears its counter. If that WRITE coincides with a hit on the same entry, the counter ends at 0.
- Without MCAST_HIT_CNT_EN: no counters are built and cfg_rd_hits is tied to 0.

## Structure
- tswitch_pkg additions:
  - group_entry_t struct {valid, base, mask, members}; members is a packed NUM_PORTS-bit vector passed as a width parameter to the module.
  - cfg_op_e enum {CFG_WRITE, CFG_INVALIDATE, CFG_READ, CFG_RSVD}.
  - HIT_CNT_WIDTH = 16.
  - ADDR_WIDTH and GROUP_ID_BITS are reused from the existing package.
- Sub-module group_match_enc: combinational, parametrised in NUM_GROUPS. It takes the match vector and returns any_match plus the lowest matching index.

## Test plan
- Post-reset lookups: 0x1000_0040 → mask 4'b1111, id 0, mc=1. 0x2ABC_0000 → 4'b0011, id 1. 0x3000_0000 → 4'b1100, id 2. 0x0000_2000 (NODE_SEL_LSB=12) → 4'b0100, id 0, mc=0.
- Priority and update: WRITE entry 5 {base 0x1000_0000, mask 0xFFFF_0000, members 4'b1010}, then look up 0x1000_1234 → id 0 (lower index wins). INVALIDATE entry 0 and repeat → id 5, 4'b1010.
- Backpressure: issue 4 back-to-back lookups with result_ready low for 3 cycles → lookup_ready=0 while stalled, results held stable, all 4 delivered in order, no loss or duplicates.
- Same cycle: WRITE entry 3 {0x4000_0000, 0xF000_0000, 4'b0001} coinciding with lookup 0x4000_0000 → miss result (4'b0001 via addr bits, mc=0). The next lookup of the same address → id 3, mc=1.
- READ round-trip with MCAST_HIT_CNT_EN: 3 hits on entry 1, then READ 1 → cfg_rd_hits=3, members 4'b0011, entry_valid=1. A WRITE to entry 1 followed by READ → hits=0.
- Reset mid-stream: assert rst_n low while result_valid=1 → all outputs 0 and the table restored to its defaults.
